// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int MDU_ITER = 32;
   localparam int CNT_W    = $clog2(MDU_ITER);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/writeback bundle between the register-file stage and the multiply/divide unit.
interface mult_div_unit_if;
   import mdu_pkg::*;

   logic        start;
   mdu_op_e     op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;
   logic        hi_wr;
   logic        lo_wr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   modport master (
      output start, op, rs_data, rt_data, flush, hi_wr, lo_wr, wr_data,
      input  busy, done, hi_out, lo_out
   );

   modport slave (
      input  start, op, rs_data, rt_data, flush, hi_wr, lo_wr, wr_data,
      output busy, done, hi_out, lo_out
   );

endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 multiply/divide with architectural HI/LO; one 64-bit accumulator
// and one 32-bit operand register shared by shift-add and restoring divide.
//
// state | meaning
// IDLE  | HI/LO writable, waiting for a launch
// CALC  | one multiply/divide step per cycle, 32 steps
// FIX   | sign correction, HI/LO update, Done pulse
module mult_div_unit
   import mdu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   mult_div_unit_if.slave  mdu
);

   mdu_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [63:0]      acc_q;
   logic [31:0]      opb_q;
   logic             is_div_q;
   logic             negq_q;
   logic             negr_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic             busy_q;
   logic             done_q;

   logic        op_signed;
   logic        op_div;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] mul_sum;
   logic [32:0] div_rem;
   logic [32:0] div_diff;
   logic [63:0] step_acc;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   assign op_signed = (mdu.op == OP_MULT) || (mdu.op == OP_DIV);
   assign op_div    = (mdu.op == OP_DIV)  || (mdu.op == OP_DIVU);
   assign sign_a    = op_signed & mdu.rs_data[31];
   assign sign_b    = op_signed & mdu.rt_data[31];
   assign mag_a     = mag32(mdu.rs_data, sign_a);
   assign mag_b     = mag32(mdu.rt_data, sign_b);

   always_comb begin
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
      div_rem  = acc_q[63:31];
      div_diff = div_rem - {1'b0, opb_q};
      step_acc = {mul_sum, acc_q[31:1]};
      if (is_div_q) begin
         step_acc = div_diff[32] ? {acc_q[62:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
      end
   end

   // A zero divisor keeps the all-ones quotient regardless of operand signs.
   always_comb begin
      prod_fix = negq_q ? (~acc_q + 64'd1) : acc_q;
      quot_fix = mag32(acc_q[31:0], negq_q && (opb_q != 32'd0));
      rem_fix  = mag32(acc_q[63:32], negr_q);
      fix_hi   = is_div_q ? rem_fix  : prod_fix[63:32];
      fix_lo   = is_div_q ? quot_fix : prod_fix[31:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mdu.hi_wr) hi_q <= mdu.wr_data;
               if (mdu.lo_wr) lo_q <= mdu.wr_data;
               if (mdu.start && !mdu.flush) begin
                  // Multiplier sits in the low half so its bits shift out as product bits shift in.
                  acc_q    <= {32'd0, op_div ? mag_a : mag_b};
                  opb_q    <= op_div ? mag_b : mag_a;
                  is_div_q <= op_div;
                  negq_q   <= sign_a ^ sign_b;
                  negr_q   <= sign_a;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               if (mdu.flush) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  acc_q <= step_acc;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(MDU_ITER - 1)) state_q <= FIX;
               end
            end
            FIX: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (!mdu.flush) begin
                  hi_q   <= fix_hi;
                  lo_q   <= fix_lo;
                  done_q <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mdu.busy   = busy_q;
   assign mdu.done   = done_q;
   assign mdu.hi_out = hi_q;
   assign mdu.lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at launch, compared on Done.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic clk;
   logic rst_n;

   mult_div_unit_if mdu();

   mult_div_unit u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .mdu     (mdu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec;
   int          n_err;
   int          done_cnt;
   logic [63:0] sb_q[$];
   logic [31:0] last_hi;
   logic [31:0] last_lo;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint          sq;
      longint          sr;
      longint unsigned uq;
      longint unsigned ur;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (op)
         2'b00: r = sa * sb;
         2'b01: r = ua * ub;
         default: begin
            if (b == 32'd0) begin
               r = {a, 32'hFFFF_FFFF};
            end else if (op == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               r  = {sr[31:0], sq[31:0]};
            end else begin
               uq = ua / ub;
               ur = ua % ub;
               r  = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && mdu.done) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            check_val("spurious_done", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            check_val("hi", {32'd0, mdu.hi_out}, {32'd0, e[63:32]});
            check_val("lo", {32'd0, mdu.lo_out}, {32'd0, e[31:0]});
            last_hi = e[63:32];
            last_lo = e[31:0];
         end
      end
   end

   // Called at a negedge; returns at the following negedge with operands scrambled.
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      mdu.start   = 1'b1;
      mdu.op      = mdu_op_e'(op);
      mdu.rs_data = a;
      mdu.rt_data = b;
      sb_q.push_back(model(op, a, b));
      @(negedge clk);
      mdu.start   = 1'b0;
      mdu.hi_wr   = 1'b0;
      mdu.lo_wr   = 1'b0;
      mdu.op      = mdu_op_e'(2'($urandom));
      mdu.rs_data = $urandom;
      mdu.rt_data = $urandom;
   endtask

   task automatic wait_done(input int pre, input bit chk_width);
      int busy_cyc;
      bit seen;
      busy_cyc = pre;
      seen     = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (mdu.done) begin
            seen = 1'b1;
            break;
         end
         if (mdu.busy) busy_cyc++;
         @(negedge clk);
      end
      check_val("done_seen", {63'd0, seen}, 64'd1);
      if (seen) check_val("busy_len", 64'(busy_cyc), 64'd33);
      if (chk_width) begin
         @(negedge clk);
         check_val("done_width", {63'd0, mdu.done}, 64'd0);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      launch(op, a, b);
      wait_done(0, 1'b1);
   endtask

   initial begin
      int d0;
      n_vec    = 0;
      n_err    = 0;
      done_cnt = 0;
      last_hi  = '0;
      last_lo  = '0;
      rst_n       = 1'b0;
      mdu.start   = 1'b0;
      mdu.op      = OP_MULT;
      mdu.rs_data = '0;
      mdu.rt_data = '0;
      mdu.flush   = 1'b0;
      mdu.hi_wr   = 1'b0;
      mdu.lo_wr   = 1'b0;
      mdu.wr_data = '0;
      repeat (3) @(negedge clk);
      check_val("rst_hi",   {32'd0, mdu.hi_out}, 64'd0);
      check_val("rst_lo",   {32'd0, mdu.lo_out}, 64'd0);
      check_val("rst_busy", {63'd0, mdu.busy},   64'd0);
      check_val("rst_done", {63'd0, mdu.done},   64'd0);
      rst_n = 1'b1;

      run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
      run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(2'b11, 32'h0000_0007, 32'h0000_0000);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
      run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE);
      for (int i = 0; i < 16; i++) begin
         logic [31:0] b;
         b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         run_op(2'(i % 4), $urandom, b);
      end

      // MTHI while busy is dropped; a second Start mid-op is ignored.
      @(negedge clk);
      launch(2'b00, 32'h0001_0003, 32'hFFFF_FFF0);
      mdu.hi_wr   = 1'b1;
      mdu.wr_data = 32'h1234_5678;
      mdu.start   = 1'b1;
      mdu.op      = OP_DIVU;
      mdu.rs_data = 32'd100;
      mdu.rt_data = 32'd3;
      @(negedge clk);
      mdu.hi_wr = 1'b0;
      mdu.start = 1'b0;
      check_val("hi_wr_busy", {32'd0, mdu.hi_out}, {32'd0, last_hi});
      wait_done(1, 1'b1);

      // MTHI / MTLO in IDLE.
      mdu.hi_wr   = 1'b1;
      mdu.wr_data = 32'h1234_5678;
      @(negedge clk);
      mdu.hi_wr = 1'b0;
      check_val("mthi_idle", {32'd0, mdu.hi_out}, 64'h1234_5678);
      mdu.lo_wr   = 1'b1;
      mdu.wr_data = 32'hCAFE_F00D;
      @(negedge clk);
      mdu.lo_wr = 1'b0;
      check_val("mtlo_idle", {32'd0, mdu.lo_out}, 64'hCAFE_F00D);
      last_hi = 32'h1234_5678;
      last_lo = 32'hCAFE_F00D;

      // Start and MTHI in the same cycle: write lands now, result overwrites at FIX.
      mdu.hi_wr   = 1'b1;
      mdu.wr_data = 32'hA5A5_A5A5;
      launch(2'b01, 32'h0000_0010, 32'h0000_0020);
      check_val("mthi_with_start", {32'd0, mdu.hi_out}, 64'hA5A5_A5A5);
      wait_done(0, 1'b0);
      // Back-to-back: launch in the Done cycle.
      launch(2'b11, 32'hFFFF_FFFF, 32'h0000_0010);
      check_val("b2b_busy", {63'd0, mdu.busy}, 64'd1);
      wait_done(0, 1'b1);

      // Flush mid-divide.
      launch(2'b10, 32'h7654_3210, 32'h0000_0123);
      repeat (10) @(negedge clk);
      void'(sb_q.pop_back());
      mdu.flush = 1'b1;
      @(negedge clk);
      mdu.flush = 1'b0;
      check_val("flush_busy", {63'd0, mdu.busy}, 64'd0);
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      check_val("flush_no_done", 64'(done_cnt - d0), 64'd0);
      check_val("flush_hi", {32'd0, mdu.hi_out}, {32'd0, last_hi});
      check_val("flush_lo", {32'd0, mdu.lo_out}, {32'd0, last_lo});

      // Flush in IDLE overrides Start.
      mdu.flush   = 1'b1;
      mdu.start   = 1'b1;
      mdu.op      = OP_MULT;
      mdu.rs_data = 32'd5;
      mdu.rt_data = 32'd6;
      @(negedge clk);
      mdu.flush = 1'b0;
      mdu.start = 1'b0;
      check_val("flush_idle_busy", {63'd0, mdu.busy}, 64'd0);
      run_op(2'b00, 32'd5, 32'd6);

      // Async reset mid-CALC.
      launch(2'b10, 32'h8765_4321, 32'h0000_0007);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("arst_hi",   {32'd0, mdu.hi_out}, 64'd0);
      check_val("arst_lo",   {32'd0, mdu.lo_out}, 64'd0);
      check_val("arst_busy", {63'd0, mdu.busy},   64'd0);
      check_val("arst_done", {63'd0, mdu.done},   64'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n   = 1'b1;
      last_hi = '0;
      last_lo = '0;
      run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_1000);
      repeat (2) @(negedge clk);
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
